// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file sequencer.
// Holds the default widths, the opcode map and the FSM state encoding.
package regfile_sequencer_pkg;

  localparam int DEF_WIDTH  = 12;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_NOP = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Bus between the sequencer and its environment (instruction source plus
// external register file).
//   master : instruction source / register file side
//   slave  : sequencer side
// Signals: instr_valid/instr_ready handshake, opcode/rd/rs1/rs2 fields,
// readAddr1/2 + readOut1/2 read ports, writeAddr/writeIn/we write port,
// done pulse and carry/zero flags.
interface regfile_sequencer_if
  import regfile_sequencer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] readAddr1;
  logic [ADDR_W-1:0] readAddr2;
  logic [WIDTH-1:0]  readOut1;
  logic [WIDTH-1:0]  readOut2;
  logic [ADDR_W-1:0] writeAddr;
  logic [WIDTH-1:0]  writeIn;
  logic              we;
  logic              done;
  logic              carry;
  logic              zero;

  modport master (
    output instr_valid, opcode, rd, rs1, rs2, readOut1, readOut2,
    input  instr_ready, readAddr1, readAddr2, writeAddr, writeIn, we,
           done, carry, zero
  );

  modport slave (
    input  instr_valid, opcode, rd, rs1, rs2, readOut1, readOut2,
    output instr_ready, readAddr1, readAddr2, writeAddr, writeIn, we,
           done, carry, zero
  );

endinterface

// File: rtl/regfile_sequencer_alu.sv
// alu_12: combinational datapath of the sequencer.
// Ports: A, B (operands), opcode -> result (truncated to WIDTH), carry.
module alu_12
  import regfile_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  opcode_t          opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One extra bit: carry-out for ADD, borrow (A < B) for SUB.
  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: begin result = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
      OP_SUB: begin result = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
      OP_AND: result = A & B;
      OP_OR:  result = A | B;
      OP_XOR: result = A ^ B;
      OP_SHL: begin result = {A[WIDTH-2:0], 1'b0}; carry = A[WIDTH-1]; end
      OP_SHR: begin result = {1'b0, A[WIDTH-1:1]}; carry = A[0];       end
      default: begin result = '0; carry = 1'b0; end
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Four-state instruction sequencer driving an external register file.
// Ports: clk, rst (async, active-high), bus (regfile_sequencer_if.slave).
// Each accepted instruction walks IDLE -> READ -> EXEC -> WRITE -> IDLE.
//
//   state | meaning
//   IDLE  | instr_ready high, waiting for instr_valid
//   READ  | readAddr1/2 show latched rs1/rs2, operands captured at exit
//   EXEC  | ALU works on captured operands, result/flags registered at exit
//   WRITE | we (non-NOP) and done high for this single cycle
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic               clk,
  input logic               rst,
  regfile_sequencer_if.slave bus
);

  state_t            state;
  opcode_t           opLatched;
  logic [ADDR_W-1:0] rdLatched;
  logic [WIDTH-1:0]  opA;
  logic [WIDTH-1:0]  opB;
  logic [WIDTH-1:0]  aluResult;
  logic              aluCarry;

  // Gated with rst so nothing is accepted while reset is held.
  assign bus.instr_ready = (state == IDLE) && !rst;

  alu_12 #(.WIDTH(WIDTH)) uAlu (
    .A      (opA),
    .B      (opB),
    .opcode (opLatched),
    .result (aluResult),
    .carry  (aluCarry)
  );

  // readAddr1/2 double as the latched rs1/rs2 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      opLatched     <= OP_ADD;
      rdLatched     <= '0;
      opA           <= '0;
      opB           <= '0;
      bus.readAddr1 <= '0;
      bus.readAddr2 <= '0;
      bus.writeAddr <= '0;
      bus.writeIn   <= '0;
      bus.we        <= 1'b0;
      bus.done      <= 1'b0;
      bus.carry     <= 1'b0;
      bus.zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            opLatched     <= opcode_t'(bus.opcode);
            rdLatched     <= bus.rd;
            bus.readAddr1 <= bus.rs1;
            bus.readAddr2 <= bus.rs2;
            state         <= READ;
          end
        end
        READ: begin
          opA   <= bus.readOut1;
          opB   <= bus.readOut2;
          state <= EXEC;
        end
        EXEC: begin
          bus.writeAddr <= rdLatched;
          bus.done      <= 1'b1;
          if (opLatched != OP_NOP) begin
            bus.we      <= 1'b1;
            bus.writeIn <= aluResult;
            bus.carry   <= aluCarry;
            bus.zero    <= (aluResult == '0);
          end
          state <= WRITE;
        end
        WRITE: begin
          bus.we   <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;
  import regfile_sequencer_pkg::*;

  localparam int W  = 12;
  localparam int AW = 3;
  localparam int M  = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sequencer_if #(.WIDTH(W), .ADDR_W(AW)) bus ();
  regfile_sequencer #(.WIDTH(W), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // External register file; pokes go through the same clocked process.
  logic [W-1:0]  rfMem [8];
  logic          pokeEn = 1'b0;
  logic [AW-1:0] pokeAddr = '0;
  logic [W-1:0]  pokeVal = '0;
  always @(posedge clk) begin
    if (bus.we) rfMem[bus.writeAddr] <= bus.writeIn;
    if (pokeEn) rfMem[pokeAddr] <= pokeVal;
  end
  assign bus.readOut1 = rfMem[bus.readAddr1];
  assign bus.readOut2 = rfMem[bus.readAddr2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model
  int refRegs [8];
  bit refCarry = 1'b0;
  bit refZero  = 1'b0;

  typedef struct {
    bit isNop;
    int addr;
    int data;
    bit c;
    bit z;
    int doneEdge;
  } exp_t;
  exp_t expQ [$];

  int nChecks = 0;
  int nPass   = 0;
  int lastAccept = 0;
  bit lastHold   = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    nChecks++;
    if (act == expv) nPass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic void model(input int op, input int a, input int b,
                                output int res, output bit c);
    c = 1'b0;
    case (op)
      0: begin res = a + b; c = (res >= M); res = res % M; end
      1: begin c = (a < b); res = (a - b + M) % M; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin c = (a >= M / 2); res = (a * 2) % M; end
      6: begin c = (a % 2 == 1); res = a / 2; end
      default: res = 0;
    endcase
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        if (expQ.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          chk("done_cycle", cyc, e.doneEdge);
          chk("we", int'(bus.we), int'(!e.isNop));
          if (!e.isNop) begin
            chk("writeAddr", int'(bus.writeAddr), e.addr);
            chk("writeIn", int'(bus.writeIn), e.data);
          end
          chk("carry", int'(bus.carry), int'(e.c));
          chk("zero", int'(bus.zero), int'(e.z));
        end
      end else begin
        chk("we_outside_write", int'(bus.we), 0);
      end
    end
  end

  task automatic drain();
    int guard = 0;
    while (expQ.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", expQ.size(), 0);
    @(negedge clk);
  endtask

  task automatic poke(input int addr, input int val);
    drain();
    pokeAddr = addr[AW-1:0];
    pokeVal  = val[W-1:0];
    pokeEn   = 1'b1;
    refRegs[addr] = val;
    @(negedge clk);
    pokeEn = 1'b0;
    lastHold = 1'b0;
  endtask

  task automatic issue(input int op, input int rd, input int rs1, input int rs2, input bit hold);
    exp_t e;
    int res;
    bit c;
    int guard = 0;
    int acc;
    @(negedge clk);
    bus.opcode = op[2:0];
    bus.rd  = rd[AW-1:0];
    bus.rs1 = rs1[AW-1:0];
    bus.rs2 = rs2[AW-1:0];
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.instr_ready) begin
      chk("accept_timeout", 0, 1);
      bus.instr_valid = 1'b0;
      lastHold = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (lastHold) chk("back_to_back_accept", acc, lastAccept + 4);
    model(op, refRegs[rs1], refRegs[rs2], res, c);
    if (op != 7) begin
      refRegs[rd] = res;
      refCarry = c;
      refZero  = (res == 0);
    end
    e.isNop = (op == 7);
    e.addr = rd;
    e.data = res;
    e.c = refCarry;
    e.z = refZero;
    e.doneEdge = acc + 2;
    expQ.push_back(e);
    lastAccept = acc;
    lastHold = hold;
    @(negedge clk);
    // Scramble the fields while the instruction is in flight.
    bus.opcode = 3'($urandom);
    bus.rd  = AW'($urandom);
    bus.rs1 = AW'($urandom);
    bus.rs2 = AW'($urandom);
    if (!hold) bus.instr_valid = 1'b0;
  endtask

  initial begin
    int keep6;
    int guard;
    bus.instr_valid = 1'b0;
    bus.opcode = '0;
    bus.rd = '0;
    bus.rs1 = '0;
    bus.rs2 = '0;

    // Reset state
    #12;
    chk("rst_we", int'(bus.we), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_writeIn", int'(bus.writeIn), 0);
    chk("rst_writeAddr", int'(bus.writeAddr), 0);
    chk("rst_flags", int'({bus.carry, bus.zero}), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", int'(bus.instr_ready), 1);

    for (int i = 0; i < 8; i++) poke(i, 0);

    // ADD overflow to zero
    poke(1, 'h7FF);
    poke(2, 'h801);
    issue(0, 3, 1, 2, 1'b0);
    // SUB with borrow
    poke(5, 'h005);
    poke(6, 'h009);
    issue(1, 4, 5, 6, 1'b0);
    // SHR shifting out the only set bit
    poke(7, 'h001);
    issue(6, 2, 7, 0, 1'b0);
    // rd aliasing both sources, then read back
    poke(1, 'h123);
    poke(0, 'h000);
    issue(0, 1, 1, 1, 1'b0);
    issue(3, 5, 1, 0, 1'b0);
    // SHL setting carry and zero, then three held-valid NOPs
    poke(4, 'h800);
    issue(5, 6, 4, 0, 1'b0);
    drain();
    issue(7, 0, 1, 2, 1'b1);
    issue(7, 1, 3, 4, 1'b1);
    issue(7, 2, 5, 6, 1'b0);
    drain();
    chk("rf_after_nops_r0", int'(rfMem[0]), refRegs[0]);

    // Asynchronous reset in the middle of EXEC
    poke(6, 'h555);
    poke(1, 'h010);
    poke(2, 'h020);
    keep6 = refRegs[6];
    @(negedge clk);
    bus.opcode = 3'b000;
    bus.rd = 3'd6;
    bus.rs1 = 3'd1;
    bus.rs2 = 3'd2;
    bus.instr_valid = 1'b1;
    guard = 0;
    while (!bus.instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_accept", int'(bus.instr_ready), 1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_we", int'(bus.we), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_flags", int'({bus.carry, bus.zero}), 0);
    refCarry = 1'b0;
    refZero  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_after_release", int'(bus.instr_ready), 1);
    repeat (6) @(negedge clk);
    chk("abort_no_writeback", int'(rfMem[6]), keep6);
    lastHold = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 8; i++) poke(i, int'($urandom_range(0, M - 1)));
    for (int n = 0; n < 60; n++) begin
      bit hold;
      hold = ($urandom_range(0, 2) != 0);
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) chk("final_rf", int'(rfMem[i]), refRegs[i]);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
